// File: rtl/uart_cmd_ctrl.sv
// Packet-level command controller: frames cmd/len/payload/chk from the UART receiver,
// executes set-image / get-image and streams a four-byte response to the transmitter.
module uart_cmd_ctrl #(
    parameter int CLOCK      = 50_000_000,
    parameter int BAUD       = 115_200,
    parameter int RX_TIMEOUT = 2
) (
    input  logic       inclk,
    input  logic       reset_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [1:0] img_cur,
    output logic       img_set_req,
    output logic [1:0] img_set_val,
    input  logic       img_set_ack,
    output logic       busy,
    output logic       err_crc,
    output logic       err_cmd,
    output logic       err_timeout
);

    localparam int TO_CYC = RX_TIMEOUT * 10 * (CLOCK / BAUD);
    localparam int TO_W   = $clog2(TO_CYC + 1);
    // Decision taken one cycle early so the registered pulse lands TO_CYC cycles after the byte.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYC - 2);

    typedef enum logic [3:0] {
        S_IDLE, S_LEN, S_DATA, S_CHK, S_EVAL, S_SETIMG,
        S_R_CMD, S_R_LEN, S_R_DATA, S_R_CHK
    } state_t;

    state_t            state_q;
    logic [7:0]        cmd_q;
    logic [7:0]        len_q;
    logic [7:0]        pay0_q;
    logic [7:0]        sum_q;
    logic [8:0]        cnt_q;
    logic [TO_W-1:0]   to_cnt_q;
    logic              crc_ok_q;
    logic [7:0]        rcmd_q;
    logic [7:0]        rdata_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              req_q;
    logic [1:0]        set_val_q;
    logic              busy_q;
    logic              err_crc_q;
    logic              err_cmd_q;
    logic              err_timeout_q;

    logic [7:0]        sum_d;
    logic [8:0]        cnt_d;
    logic [8:0]        pay_len;
    logic [7:0]        resp_chk;

    always_comb begin
        sum_d    = sum_q + rx_data;
        cnt_d    = cnt_q + 9'd1;
        pay_len  = (len_q == 8'd0) ? 9'd256 : {1'b0, len_q};
        resp_chk = ~(rcmd_q + 8'h01 + rdata_q);
    end

    always_ff @(posedge inclk) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            cmd_q         <= '0;
            len_q         <= '0;
            pay0_q        <= '0;
            sum_q         <= '0;
            cnt_q         <= '0;
            to_cnt_q      <= '0;
            crc_ok_q      <= 1'b0;
            rcmd_q        <= '0;
            rdata_q       <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            req_q         <= 1'b0;
            set_val_q     <= '0;
            busy_q        <= 1'b0;
            err_crc_q     <= 1'b0;
            err_cmd_q     <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            err_crc_q     <= 1'b0;
            err_cmd_q     <= 1'b0;
            err_timeout_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (rx_valid) begin
                        cmd_q    <= rx_data;
                        sum_q    <= rx_data;
                        cnt_q    <= '0;
                        to_cnt_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_LEN;
                    end
                end

                S_LEN, S_DATA, S_CHK: begin
                    if (rx_valid) begin
                        to_cnt_q <= '0;
                        if (state_q == S_LEN) begin
                            len_q   <= rx_data;
                            sum_q   <= sum_d;
                            state_q <= S_DATA;
                        end else if (state_q == S_DATA) begin
                            sum_q <= sum_d;
                            if (cnt_q == 9'd0)
                                pay0_q <= rx_data;
                            cnt_q <= cnt_d;
                            if (cnt_d == pay_len)
                                state_q <= S_CHK;
                        end else begin
                            crc_ok_q <= (rx_data == ~sum_q);
                            state_q  <= S_EVAL;
                        end
                    end else if (to_cnt_q == TO_LAST) begin
                        err_timeout_q <= 1'b1;
                        to_cnt_q      <= '0;
                        busy_q        <= 1'b0;
                        state_q       <= S_IDLE;
                    end else begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end

                S_EVAL: begin
                    if (!crc_ok_q) begin
                        err_crc_q <= 1'b1;
                        busy_q    <= 1'b0;
                        state_q   <= S_IDLE;
                    end else if (cmd_q == 8'h53 && len_q == 8'd1) begin
                        set_val_q <= pay0_q[1:0];
                        req_q     <= 1'b1;
                        state_q   <= S_SETIMG;
                    end else if (cmd_q == 8'h43 && len_q == 8'd1) begin
                        rcmd_q     <= 8'h43;
                        rdata_q    <= {6'd0, img_cur};
                        tx_data_q  <= 8'h43;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_R_CMD;
                    end else begin
                        err_cmd_q  <= 1'b1;
                        rcmd_q     <= 8'h45;
                        rdata_q    <= cmd_q;
                        tx_data_q  <= 8'h45;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_R_CMD;
                    end
                end

                S_SETIMG: begin
                    if (img_set_ack) begin
                        req_q      <= 1'b0;
                        rcmd_q     <= 8'h53;
                        rdata_q    <= {6'd0, set_val_q};
                        tx_data_q  <= 8'h53;
                        tx_valid_q <= 1'b1;
                        state_q    <= S_R_CMD;
                    end
                end

                S_R_CMD: begin
                    if (tx_ready) begin
                        tx_data_q <= 8'h01;
                        state_q   <= S_R_LEN;
                    end
                end

                S_R_LEN: begin
                    if (tx_ready) begin
                        tx_data_q <= rdata_q;
                        state_q   <= S_R_DATA;
                    end
                end

                S_R_DATA: begin
                    if (tx_ready) begin
                        tx_data_q <= resp_chk;
                        state_q   <= S_R_CHK;
                    end
                end

                S_R_CHK: begin
                    if (tx_ready) begin
                        tx_valid_q <= 1'b0;
                        busy_q     <= 1'b0;
                        state_q    <= S_IDLE;
                    end
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_data     = tx_data_q;
    assign tx_valid    = tx_valid_q;
    assign img_set_req = req_q;
    assign img_set_val = set_val_q;
    assign busy        = busy_q;
    assign err_crc     = err_crc_q;
    assign err_cmd     = err_cmd_q;
    assign err_timeout = err_timeout_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Scoreboard bench for uart_cmd_ctrl: expected response bytes are queued by the stimulus
// and popped by a monitor on every transmitter handshake.
module tb_uart_cmd_ctrl;

    logic       inclk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic [1:0] img_cur = 2'd3;
    logic       img_set_req;
    logic [1:0] img_set_val;
    logic       img_set_ack = 1'b0;
    logic       busy;
    logic       err_crc;
    logic       err_cmd;
    logic       err_timeout;

    uart_cmd_ctrl dut (
        .inclk       (inclk),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .img_cur     (img_cur),
        .img_set_req (img_set_req),
        .img_set_val (img_set_val),
        .img_set_ack (img_set_ack),
        .busy        (busy),
        .err_crc     (err_crc),
        .err_cmd     (err_cmd),
        .err_timeout (err_timeout)
    );

    always #5 inclk = ~inclk;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] exp_q[$];
    int         crc_cnt = 0, cmd_cnt = 0, to_cnt = 0, req_cnt = 0;
    logic [1:0] set_val_seen = 2'd0;
    logic       tx_toggle = 1'b0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on handshake, stall stability, error pulse counting.
    always @(negedge inclk) begin
        if (reset_n) begin
            if (stall_prev) begin
                check("tx_hold_valid", {31'd0, tx_valid}, 32'd1);
                check("tx_hold_data", {24'd0, tx_data}, {24'd0, stall_data});
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("tx_unexpected", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("tx_byte", {24'd0, tx_data}, {24'd0, e});
                    $display("tx byte %02h (expected %02h)", tx_data, e);
                end
            end
            if (err_crc)     crc_cnt++;
            if (err_cmd)     cmd_cnt++;
            if (err_timeout) to_cnt++;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Image configuration responder: acks one cycle after the request is seen.
    initial begin
        forever begin
            @(negedge inclk);
            if (img_set_req && reset_n) begin
                req_cnt++;
                set_val_seen = img_set_val;
                @(posedge inclk); #1 img_set_ack = 1'b1;
                @(posedge inclk); #1 img_set_ack = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge inclk); #1;
            tx_ready = tx_toggle ? ~tx_ready : 1'b1;
        end
    end

    // Called at posedge+1; returns at posedge+1 of the following cycle.
    task automatic rx_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge inclk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic push_resp(input logic [7:0] c, input logic [7:0] d, input logic [7:0] k);
        exp_q.push_back(c);
        exp_q.push_back(8'h01);
        exp_q.push_back(d);
        exp_q.push_back(k);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy || exp_q.size() != 0) && n < 2000) begin
            @(posedge inclk); #1;
            n++;
        end
        check(name, {31'd0, (n < 2000)}, 32'd1);
        repeat (3) @(posedge inclk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        check(name, {16'd0, tx_data, tx_valid, img_set_req, img_set_val, busy,
                     err_crc, err_cmd, err_timeout}, 32'd0);
    endtask

    initial begin
        int c0, e0, r0, t0, elapsed;

        repeat (3) @(posedge inclk);
        #1;
        check_all_zero("reset_outputs");
        reset_n = 1'b1;
        @(posedge inclk); #1;

        // Set image 3
        c0 = crc_cnt; e0 = cmd_cnt; r0 = req_cnt;
        push_resp(8'h53, 8'h03, 8'hA8);
        rx_byte(8'h53);
        check("busy_after_cmd", {31'd0, busy}, 32'd1);
        rx_byte(8'h01); rx_byte(8'h03); rx_byte(8'hA8);
        @(posedge inclk); #1;
        check("set_req_n2", {31'd0, img_set_req}, 32'd1);
        check("set_val_n2", {30'd0, img_set_val}, 32'd3);
        @(posedge inclk); #1;
        check("set_txv_ack_cycle", {31'd0, tx_valid}, 32'd0);
        @(posedge inclk); #1;
        check("set_txv_after_ack", {31'd0, tx_valid}, 32'd1);
        check("set_req_dropped", {31'd0, img_set_req}, 32'd0);
        wait_idle("set_done");
        check("set_req_count", 32'(req_cnt - r0), 32'd1);
        check("set_val_seen", {30'd0, set_val_seen}, 32'd3);
        check("set_no_err", 32'(crc_cnt - c0 + cmd_cnt - e0), 32'd0);
        $display("set image 3 done");

        // Get image, then again with a stalling transmitter
        for (int pass = 0; pass < 2; pass++) begin
            r0 = req_cnt;
            tx_toggle = (pass == 1);
            push_resp(8'h43, 8'h03, 8'hB8);
            rx_byte(8'h43); rx_byte(8'h01); rx_byte(8'h00); rx_byte(8'hBB);
            check("get_eval_txv", {31'd0, tx_valid}, 32'd0);
            @(posedge inclk); #1;
            check("get_txv_n2", {31'd0, tx_valid}, 32'd1);
            check("get_txd_n2", {24'd0, tx_data}, 32'h43);
            wait_idle("get_done");
            check("get_no_req", 32'(req_cnt - r0), 32'd0);
            $display("get image pass %0d done", pass);
        end
        tx_toggle = 1'b0;

        // Bad checksum
        c0 = crc_cnt; r0 = req_cnt;
        rx_byte(8'h53); rx_byte(8'h01); rx_byte(8'h03); rx_byte(8'h00);
        @(posedge inclk); #1;
        check("crc_pulse_n2", {31'd0, err_crc}, 32'd1);
        check("crc_idle_n2", {31'd0, busy}, 32'd0);
        @(posedge inclk); #1;
        check("crc_pulse_end", {31'd0, err_crc}, 32'd0);
        repeat (5) @(posedge inclk);
        #1;
        check("crc_count", 32'(crc_cnt - c0), 32'd1);
        check("crc_no_req", 32'(req_cnt - r0), 32'd0);
        check("crc_no_txv", {31'd0, tx_valid}, 32'd0);
        $display("bad checksum done");

        // Timeout after 53 01
        t0 = to_cnt;
        rx_byte(8'h53); rx_byte(8'h01);
        elapsed = 1;
        while (!err_timeout && elapsed < 9000) begin
            @(posedge inclk); #1;
            elapsed++;
        end
        check("timeout_cycles", 32'(elapsed), 32'd8680);
        check("timeout_idle", {31'd0, busy}, 32'd0);
        @(posedge inclk); #1;
        check("timeout_count", 32'(to_cnt - t0), 32'd1);
        push_resp(8'h43, 8'h03, 8'hB8);
        rx_byte(8'h43); rx_byte(8'h01); rx_byte(8'h00); rx_byte(8'hBB);
        wait_idle("after_timeout_done");
        $display("timeout done after %0d cycles", elapsed);

        // Unknown command, len 3: 74+03+11+22+33 = DD, chk = 22
        e0 = cmd_cnt;
        push_resp(8'h45, 8'h74, 8'h45);
        rx_byte(8'h74); rx_byte(8'h03);
        rx_byte(8'h11); rx_byte(8'h22); rx_byte(8'h33); rx_byte(8'h22);
        wait_idle("unk3_done");
        check("unk3_err_cmd", 32'(cmd_cnt - e0), 32'd1);
        $display("unknown cmd len 3 done");

        // Unknown command, len 0 = 256 bytes 00..FF: sum 74+80 = F4, chk = 0B
        e0 = cmd_cnt;
        push_resp(8'h45, 8'h74, 8'h45);
        rx_byte(8'h74); rx_byte(8'h00);
        for (int i = 0; i < 256; i++) begin
            rx_byte(8'(i));
            if (i == 254)
                check("len256_busy", {31'd0, busy}, 32'd1);
        end
        check("len256_no_early_tx", {31'd0, tx_valid}, 32'd0);
        rx_byte(8'h0B);
        wait_idle("unk256_done");
        check("unk256_err_cmd", 32'(cmd_cnt - e0), 32'd1);
        $display("unknown cmd len 256 done");

        // Reset mid-packet
        rx_byte(8'h53); rx_byte(8'h01);
        reset_n = 1'b0;
        @(posedge inclk); #1;
        reset_n = 1'b1;
        check_all_zero("midreset_outputs");
        r0 = req_cnt;
        push_resp(8'h53, 8'h02, 8'hA9);
        rx_byte(8'h53); rx_byte(8'h01); rx_byte(8'h02); rx_byte(8'hA9);
        wait_idle("midreset_set_done");
        check("midreset_req", 32'(req_cnt - r0), 32'd1);
        check("midreset_val", {30'd0, set_val_seen}, 32'd2);
        check("midreset_img_val", {30'd0, img_set_val}, 32'd2);
        $display("reset mid-packet done");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
